// File: rtl/bomb_pkg.sv
// Shared types for the bomb-game timing blocks: BCD digit and stopwatch control states.
package bomb_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_RUN,
    SW_PAUSE,
    SW_DONE
  } sw_state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit: increments on inc, wraps to 0 after LIMIT and flags carry to the next digit.
module bcd_digit
  import bomb_pkg::*;
#(
  parameter bcd_t LIMIT = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry
);

  bcd_t digit_q, digit_d;

  assign carry = inc && (digit_q == LIMIT);
  assign digit = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == LIMIT) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/stopwatch.sv
// MM:SS BCD up-counting stopwatch with start/stop/clear FSM, 1 s prescaler and saturating overflow.
// Optional lap snapshot registers are built when STOPWATCH_LAP_EN is defined.
module stopwatch
  import bomb_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MAX_MIN  = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic clear,
`ifdef STOPWATCH_LAP_EN
  input  logic lap,
  output logic lap_valid,
  output bcd_t lap_sec_ones,
  output bcd_t lap_sec_tens,
  output bcd_t lap_min_ones,
  output bcd_t lap_min_tens,
`endif
  output logic running,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic overflow
);

  localparam int unsigned PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam bcd_t        MAX_MT = 4'(MAX_MIN / 10);
  localparam bcd_t        MAX_MO = 4'(MAX_MIN % 10);

  sw_state_t       state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, running_d;
  logic            overflow_q, overflow_d;
  logic            tick, sat, at_max, inc_so;
  logic            so_carry, st_carry, mo_carry, mt_carry;

  assign at_max = (min_tens == MAX_MT) && (min_ones == MAX_MO) &&
                  (sec_tens == 4'd5) && (sec_ones == 4'd9);
  assign inc_so = tick && !sat;

  // Next-state: clear beats stop beats start; stop also freezes the prescaler that cycle.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    overflow_d = overflow_q;
    tick       = 1'b0;
    sat        = 1'b0;
    if (state_q == SW_RUN && !clear && !stop) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
        sat     = at_max;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (clear) begin
      state_d    = SW_IDLE;
      presc_d    = '0;
      overflow_d = 1'b0;
    end else if (stop) begin
      if (state_q == SW_RUN) state_d = SW_PAUSE;
    end else if (sat || mt_carry) begin
      state_d    = SW_DONE;
      overflow_d = 1'b1;
    end else if (start && (state_q == SW_IDLE || state_q == SW_PAUSE)) begin
      state_d = SW_RUN;
    end
    running_d = (state_d == SW_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SW_IDLE;
      presc_q    <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = running_q;
  assign overflow = overflow_q;

  bcd_digit #(.LIMIT(4'd9)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(inc_so),   .digit(sec_ones), .carry(so_carry)
  );
  bcd_digit #(.LIMIT(4'd5)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(so_carry), .digit(sec_tens), .carry(st_carry)
  );
  bcd_digit #(.LIMIT(4'd9)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(st_carry), .digit(min_ones), .carry(mo_carry)
  );
  bcd_digit #(.LIMIT(4'd9)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(mo_carry), .digit(min_tens), .carry(mt_carry)
  );

`ifdef STOPWATCH_LAP_EN
  // Lap captures the registered (pre-increment) digits, so a coincident tick is not seen.
  logic snap;
  logic lap_valid_q;
  bcd_t lap_so_q, lap_st_q, lap_mo_q, lap_mt_q;

  assign snap = lap && !clear && (state_q == SW_RUN || state_q == SW_DONE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_valid_q <= 1'b0;
      lap_so_q    <= '0;
      lap_st_q    <= '0;
      lap_mo_q    <= '0;
      lap_mt_q    <= '0;
    end else begin
      lap_valid_q <= snap;
      if (snap) begin
        lap_so_q <= sec_ones;
        lap_st_q <= sec_tens;
        lap_mo_q <= min_ones;
        lap_mt_q <= min_tens;
      end
    end
  end

  assign lap_valid    = lap_valid_q;
  assign lap_sec_ones = lap_so_q;
  assign lap_sec_tens = lap_st_q;
  assign lap_min_ones = lap_mo_q;
  assign lap_min_tens = lap_mt_q;
`endif

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch at TICK_DIV=4, MAX_MIN=1; lap checks build when STOPWATCH_LAP_EN is defined.
`timescale 1ns/1ps
module tb_stopwatch;
  import bomb_pkg::*;

  logic clk = 1'b0;
  logic rst, start, stop, clear;
  logic running, overflow;
  bcd_t sec_ones, sec_tens, min_ones, min_tens;
`ifdef STOPWATCH_LAP_EN
  logic lap, lap_valid;
  bcd_t lap_sec_ones, lap_sec_tens, lap_min_ones, lap_min_tens;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch #(.TICK_DIV(4), .MAX_MIN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_valid(lap_valid),
    .lap_sec_ones(lap_sec_ones), .lap_sec_tens(lap_sec_tens),
    .lap_min_ones(lap_min_ones), .lap_min_tens(lap_min_tens),
`endif
    .running(running), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n edges; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mmss();
    return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    step(1);
    rst = 1'b0;
    check("rst_time", mmss(), 32'h0000);
    check("rst_running", 32'(running), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // start and first second
    start = 1'b1; step(1); start = 1'b0;
    check("start_running", 32'(running), 32'd1);
    check("start_time", mmss(), 32'h0000);
    step(3);
    check("pre_tick", mmss(), 32'h0000);
    step(1);
    check("first_tick", mmss(), 32'h0001);

    // 40 and 240 RUN cycles
    step(36);
    check("t_00_10", mmss(), 32'h0010);
    step(200);
    check("t_01_00", mmss(), 32'h0100);
    check("run_still", 32'(running), 32'd1);

    // pause at prescaler 2, resume needs 2 more RUN cycles
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_running", 32'(running), 32'd0);
    step(20);
    check("pause_frozen", mmss(), 32'h0100);
    start = 1'b1; step(1); start = 1'b0;
    check("resume_running", 32'(running), 32'd1);
    step(1);
    check("resume_pre", mmss(), 32'h0100);
    step(1);
    check("resume_tick", mmss(), 32'h0101);

    // saturation at 01:59
    step(232);
    check("t_01_59", mmss(), 32'h0159);
    check("pre_sat_ovf", 32'(overflow), 32'd0);
    step(3);
    check("pre_sat_run", 32'(running), 32'd1);
    step(1);
    check("sat_time", mmss(), 32'h0159);
    check("sat_ovf", 32'(overflow), 32'd1);
    check("sat_running", 32'(running), 32'd0);
    start = 1'b1; step(1); start = 1'b0;
    step(8);
    check("done_start_ign", 32'(running), 32'd0);
    check("done_hold", mmss(), 32'h0159);
    clear = 1'b1; step(1); clear = 1'b0;
    check("clr_time", mmss(), 32'h0000);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_running", 32'(running), 32'd0);
    step(5);
    check("idle_no_count", mmss(), 32'h0000);

    // start+stop together in IDLE
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("ss_running", 32'(running), 32'd0);
    step(8);
    check("ss_time", mmss(), 32'h0000);

    // clear+start together in RUN
    start = 1'b1; step(1); start = 1'b0;
    step(6);
    check("run2_time", mmss(), 32'h0001);
    clear = 1'b1; start = 1'b1; step(1); clear = 1'b0; start = 1'b0;
    check("cs_running", 32'(running), 32'd0);
    check("cs_time", mmss(), 32'h0000);
    step(8);
    check("cs_idle", mmss(), 32'h0000);

    // rst mid-count
    start = 1'b1; step(1); start = 1'b0;
    step(9);
    check("run3_time", mmss(), 32'h0002);
    rst = 1'b1; step(1); rst = 1'b0;
    check("mid_rst_time", mmss(), 32'h0000);
    check("mid_rst_running", 32'(running), 32'd0);
    step(5);
    check("mid_rst_idle", mmss(), 32'h0000);

`ifdef STOPWATCH_LAP_EN
    // lap coinciding with the 00:03 -> 00:04 tick
    start = 1'b1; step(1); start = 1'b0;
    step(12);
    check("lap_pre_time", mmss(), 32'h0003);
    step(3);
    lap = 1'b1; step(1); lap = 1'b0;
    check("lap_live", mmss(), 32'h0004);
    check("lap_value", {16'h0, lap_min_tens, lap_min_ones, lap_sec_tens, lap_sec_ones}, 32'h0003);
    check("lap_valid_hi", 32'(lap_valid), 32'd1);
    step(1);
    check("lap_valid_lo", 32'(lap_valid), 32'd0);
    check("lap_hold", {16'h0, lap_min_tens, lap_min_ones, lap_sec_tens, lap_sec_ones}, 32'h0003);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
